// File: rtl/bit_deser_if.sv
// Serial-in / word-out bus for bit_deser: bit qualifier, data bit and ack in,
// assembled word with done/overrun status out.
interface bit_deser_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             in;
  logic             ack;
  logic [WIDTH-1:0] out;
  logic             done;
  logic             ovr;

  modport master (
    output en,
    output in,
    output ack,
    input  out,
    input  done,
    input  ovr
  );

  modport slave (
    input  en,
    input  in,
    input  ack,
    output out,
    output done,
    output ovr
  );
endinterface

// File: rtl/bit_deser.sv
// LSB-first serial-to-parallel deserialiser with a level done flag, ack
// handshake and a sticky overrun flag when an unacknowledged word is overwritten.
module bit_deser #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst,
  bit_deser_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    idx;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] out_q, out_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             complete;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving IDLE always starts at bit 0, which re-aligns to the transmitter.
  always_comb begin
    state_d  = bus.en ? RECV : IDLE;
    idx      = (state_q == RECV) ? cnt_q : '0;
    word     = shreg_q;
    word[idx] = bus.in;
    complete = bus.en && (idx == LAST);

    cnt_d   = '0;
    shreg_d = shreg_q;
    out_d   = out_q;
    done_d  = done_q;
    ovr_d   = ovr_q;

    if (bus.en) begin
      shreg_d = word;
      if (complete) begin
        out_d  = word;
        done_d = 1'b1;
        if (done_q && !bus.ack) begin
          ovr_d = 1'b1;
        end
      end else begin
        cnt_d = idx + CW'(1);
      end
    end

    if (!complete && bus.ack && done_q) begin
      done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.done = done_q;
  assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_bit_deser.sv
// Directed bench for bit_deser (WIDTH=8): a scoreboard queue of expected words
// drained by a monitor on each completion, plus direct status checks.
module tb_bit_deser;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] word;
    logic             ovr;
  } exp_t;

  logic clk;
  logic rst;
  logic monOn;
  int   tests;
  int   failed;
  exp_t sbq[$];

  bit_deser_if #(.WIDTH(WIDTH)) bus ();

  bit_deser #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic e, input logic b, input logic a);
    @(negedge clk);
    rst     = r;
    bus.en  = e;
    bus.in  = b;
    bus.ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] expOut,
                             input logic expDone, input logic expOvr);
    tests++;
    if (bus.out !== expOut || bus.done !== expDone || bus.ovr !== expOvr) begin
      failed++;
      $display("[TB] FAIL %s: got out=%h done=%b ovr=%b, expected out=%h done=%b ovr=%b",
               name, bus.out, bus.done, bus.ovr, expOut, expDone, expOvr);
    end
  endtask

  // Pushes the expected completion, then streams the word LSB first on consecutive edges.
  task automatic sendWord(input logic [WIDTH-1:0] w, input logic expOvr, input logic ackLast);
    exp_t e;
    e.word = w;
    e.ovr  = expOvr;
    sbq.push_back(e);
    for (int i = 0; i < WIDTH; i++) begin
      applyStimulus(1'b0, 1'b1, w[i], (i == WIDTH - 1) ? ackLast : 1'b0);
    end
  endtask

  // Monitor: a completion is done rising, or out changing while done stays high.
  initial begin
    logic             prevDone;
    logic [WIDTH-1:0] prevOut;
    exp_t             e;
    wait (monOn === 1'b1);
    prevDone = 1'b0;
    prevOut  = '0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1 && (prevDone !== 1'b1 || bus.out !== prevOut)) begin
        tests++;
        if (sbq.size() == 0) begin
          failed++;
          $display("[TB] FAIL unexpected word: got out=%h ovr=%b, expected no completion",
                   bus.out, bus.ovr);
        end else begin
          e = sbq.pop_front();
          if (bus.out !== e.word || bus.ovr !== e.ovr) begin
            failed++;
            $display("[TB] FAIL scoreboard word: got out=%h ovr=%b, expected out=%h ovr=%b",
                     bus.out, bus.ovr, e.word, e.ovr);
          end
        end
      end
      prevDone = bus.done;
      prevOut  = bus.out;
    end
  end

  initial begin
    tests   = 0;
    failed  = 0;
    monOn   = 1'b0;
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.in  = 1'b0;
    bus.ack = 1'b0;

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset", 8'h00, 1'b0, 1'b0);
    monOn = 1'b1;

    // Single word, then ack, then a stray ack while done is low
    sendWord(8'hA5, 1'b0, 1'b0);
    checkOutput("single word", 8'hA5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ack clears done", 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("ack with done low", 8'hA5, 1'b0, 1'b0);

    // Abort after 5 bits, then a full word must start from bit 0
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("partial word", 8'hA5, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("abort edge", 8'hA5, 1'b0, 1'b0);
    sendWord(8'h81, 1'b0, 1'b0);
    checkOutput("after abort", 8'h81, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Back-to-back words without ack: overrun
    sendWord(8'h3C, 1'b0, 1'b0);
    checkOutput("overrun first", 8'h3C, 1'b1, 1'b0);
    sendWord(8'hC3, 1'b1, 1'b0);
    checkOutput("overrun second", 8'hC3, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ack keeps ovr", 8'hC3, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovr sticky", 8'hC3, 1'b0, 1'b1);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset clears ovr", 8'h00, 1'b0, 1'b0);

    // Ack on the completing edge avoids the overrun
    sendWord(8'h3C, 1'b0, 1'b0);
    sendWord(8'hC3, 1'b0, 1'b1);
    checkOutput("ack on completion", 8'hC3, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("ack after completion", 8'hC3, 1'b0, 1'b0);

    // Reset mid-word discards collected bits
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("reset mid word", 8'h00, 1'b0, 1'b0);
    sendWord(8'h5A, 1'b0, 1'b0);
    checkOutput("after mid reset", 8'h5A, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

    // Idle edges with toggling data leave everything unchanged
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, i[0], 1'b0);
    checkOutput("idle hold", 8'h5A, 1'b0, 1'b0);

    // Reset wins over a completing en edge
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("reset priority", 8'h00, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    tests++;
    if (sbq.size() != 0) begin
      failed++;
      $display("[TB] FAIL scoreboard drain: got %0d pending words, expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
